// File: rtl/smem_pkg.sv
// Shared types and constants for the occurrence-lookup memory side.
package smem_pkg;

   localparam int unsigned READ_NUM_WIDTH = 6;
   localparam int unsigned CL             = 512;
   localparam int unsigned ADDR_W         = 42;
   localparam int unsigned A_W            = 32;
   localparam int unsigned B_W            = 64;
   localparam int unsigned A_OFF          = 0;
   localparam int unsigned B_OFF          = 128;
   localparam int unsigned USED_W         = B_OFF + 4 * B_W;

   // Packed so that the struct image equals line[USED_W-1:0].
   typedef struct packed {
      logic [B_W-1:0] b3;
      logic [B_W-1:0] b2;
      logic [B_W-1:0] b1;
      logic [B_W-1:0] b0;
      logic [A_W-1:0] a3;
      logic [A_W-1:0] a2;
      logic [A_W-1:0] a1;
      logic [A_W-1:0] a0;
   } occ_cnt_t;

endpackage

// File: rtl/occ_line_slice.sv
// Splits one returned cache line into its occurrence counter fields.
module occ_line_slice
   import smem_pkg::*;
(
   input  logic [CL-1:0] line_i,
   output occ_cnt_t      cnt_o
);

   logic unused_hi;

   assign cnt_o.a0 = line_i[A_OFF + 0 * A_W +: A_W];
   assign cnt_o.a1 = line_i[A_OFF + 1 * A_W +: A_W];
   assign cnt_o.a2 = line_i[A_OFF + 2 * A_W +: A_W];
   assign cnt_o.a3 = line_i[A_OFF + 3 * A_W +: A_W];
   assign cnt_o.b0 = line_i[B_OFF + 0 * B_W +: B_W];
   assign cnt_o.b1 = line_i[B_OFF + 1 * B_W +: B_W];
   assign cnt_o.b2 = line_i[B_OFF + 2 * B_W +: B_W];
   assign cnt_o.b3 = line_i[B_OFF + 3 * B_W +: B_W];

   assign unused_hi = ^line_i[CL-1:USED_W];

endmodule

// File: rtl/bwt_occ_responder.sv
// Issues k/l line reads per lookup, gathers out-of-order returns into slots and
// hands the counter sets back in request order.
module bwt_occ_responder #(
   parameter int unsigned SLOTS          = 8,
   parameter int unsigned READ_NUM_WIDTH = smem_pkg::READ_NUM_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      request_valid,
   output logic                      request_ready,
   input  logic [READ_NUM_WIDTH-1:0] read_num_req,
   input  logic [41:0]               addr_k,
   input  logic [41:0]               addr_l,
   output logic                      mem_rd_valid,
   input  logic                      mem_rd_ready,
   output logic [41:0]               mem_rd_addr,
   output logic [$clog2(SLOTS):0]    mem_rd_tag,
   input  logic                      mem_resp_valid,
   input  logic [$clog2(SLOTS):0]    mem_resp_tag,
   input  logic [511:0]              mem_resp_data,
   input  logic                      stall,
   output logic                      resp_valid,
   output logic [READ_NUM_WIDTH-1:0] read_num,
   output logic [31:0]               cnt_a0, cnt_a1, cnt_a2, cnt_a3,
   output logic [63:0]               cnt_b0, cnt_b1, cnt_b2, cnt_b3,
   output logic [31:0]               cntl_a0, cntl_a1, cntl_a2, cntl_a3,
   output logic [63:0]               cntl_b0, cntl_b1, cntl_b2, cntl_b3
);
   import smem_pkg::*;

   localparam int unsigned PW       = $clog2(SLOTS);
   localparam logic [PW:0] PtrOne   = 1;
   localparam logic [PW:0] SlotsCnt = (PW + 1)'(SLOTS);
   localparam logic [1:0]  StIdle   = 2'd0;
   localparam logic [1:0]  StIssueK = 2'd1;
   localparam logic [1:0]  StIssueL = 2'd2;

   // Pointers carry a wrap bit so issue == alloc is unambiguous when full.
   logic [1:0]                state_q, state_d;
   logic [PW:0]               alloc_q, issue_q, retire_q, count_q, count_d;
   logic [READ_NUM_WIDTH-1:0] rn_q [SLOTS];
   logic [ADDR_W-1:0]         ak_q [SLOTS];
   logic [ADDR_W-1:0]         al_q [SLOTS];
   occ_cnt_t                  ck_q [SLOTS];
   occ_cnt_t                  cl_q [SLOTS];
   logic [SLOTS-1:0]          busy_q, same_q, got_k_q, got_l_q;
   logic                      out_valid_q;
   logic [READ_NUM_WIDTH-1:0] out_rn_q;
   occ_cnt_t                  out_k_q, out_l_q;

   logic [PW-1:0] alloc_idx, issue_idx, retire_idx, rsp_idx;
   logic          accept, rd_fire, issue_adv, pend_after, rsp_half;
   logic          hit_k, hit_l, byp_k, byp_l, retire;
   occ_cnt_t      rsp_cnt, ret_k, ret_l;

   occ_line_slice u_slice (
      .line_i (mem_resp_data),
      .cnt_o  (rsp_cnt)
   );

   assign alloc_idx  = alloc_q[PW-1:0];
   assign issue_idx  = issue_q[PW-1:0];
   assign retire_idx = retire_q[PW-1:0];
   assign rsp_idx    = mem_resp_tag[PW:1];
   assign rsp_half   = mem_resp_tag[0];

   assign request_ready = count_q < SlotsCnt;
   assign accept        = request_valid & request_ready;

   assign mem_rd_valid = state_q != StIdle;
   assign rd_fire      = mem_rd_valid & mem_rd_ready;
   assign mem_rd_addr  = (state_q == StIssueK) ? ak_q[issue_idx] :
                         (state_q == StIssueL) ? al_q[issue_idx] : '0;
   assign mem_rd_tag   = mem_rd_valid ? {issue_idx, state_q == StIssueL} : '0;
   assign issue_adv    = rd_fire & ((state_q == StIssueL) | same_q[issue_idx]);
   assign pend_after   = ((issue_q + PtrOne) != alloc_q) | accept;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if ((issue_q != alloc_q) | accept) state_d = StIssueK;
         StIssueK: if (mem_rd_ready) begin
            if (same_q[issue_idx]) state_d = pend_after ? StIssueK : StIdle;
            else                   state_d = StIssueL;
         end
         StIssueL: if (mem_rd_ready) state_d = pend_after ? StIssueK : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // A line landing on the head slot retires in the same cycle via bypass.
   assign hit_k  = mem_resp_valid & busy_q[rsp_idx] & ~rsp_half;
   assign hit_l  = mem_resp_valid & busy_q[rsp_idx] & (rsp_half | same_q[rsp_idx]);
   assign byp_k  = hit_k & (rsp_idx == retire_idx);
   assign byp_l  = hit_l & (rsp_idx == retire_idx);
   assign retire = busy_q[retire_idx] & (got_k_q[retire_idx] | byp_k) &
                   (got_l_q[retire_idx] | byp_l) & (~out_valid_q | ~stall);
   assign ret_k  = byp_k ? rsp_cnt : ck_q[retire_idx];
   assign ret_l  = byp_l ? rsp_cnt : cl_q[retire_idx];

   always_comb begin
      count_d = count_q;
      if (accept & ~retire)      count_d = count_q + PtrOne;
      else if (retire & ~accept) count_d = count_q - PtrOne;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         alloc_q     <= '0;
         issue_q     <= '0;
         retire_q    <= '0;
         count_q     <= '0;
         busy_q      <= '0;
         same_q      <= '0;
         got_k_q     <= '0;
         got_l_q     <= '0;
         out_valid_q <= 1'b0;
         out_rn_q    <= '0;
         out_k_q     <= '0;
         out_l_q     <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            rn_q[i] <= '0;
            ak_q[i] <= '0;
            al_q[i] <= '0;
            ck_q[i] <= '0;
            cl_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (issue_adv) issue_q <= issue_q + PtrOne;
         if (accept) begin
            rn_q[alloc_idx]    <= read_num_req;
            ak_q[alloc_idx]    <= addr_k;
            al_q[alloc_idx]    <= addr_l;
            same_q[alloc_idx]  <= addr_k == addr_l;
            busy_q[alloc_idx]  <= 1'b1;
            got_k_q[alloc_idx] <= 1'b0;
            got_l_q[alloc_idx] <= 1'b0;
            alloc_q            <= alloc_q + PtrOne;
         end
         if (hit_k) begin
            ck_q[rsp_idx]    <= rsp_cnt;
            got_k_q[rsp_idx] <= 1'b1;
         end
         if (hit_l) begin
            cl_q[rsp_idx]    <= rsp_cnt;
            got_l_q[rsp_idx] <= 1'b1;
         end
         if (retire) begin
            busy_q[retire_idx]  <= 1'b0;
            got_k_q[retire_idx] <= 1'b0;
            got_l_q[retire_idx] <= 1'b0;
            retire_q            <= retire_q + PtrOne;
            out_valid_q         <= 1'b1;
            out_rn_q            <= rn_q[retire_idx];
            out_k_q             <= ret_k;
            out_l_q             <= ret_l;
         end else if (out_valid_q & ~stall) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign resp_valid = out_valid_q;
   assign read_num   = out_rn_q;
   assign cnt_a0     = out_k_q.a0;
   assign cnt_a1     = out_k_q.a1;
   assign cnt_a2     = out_k_q.a2;
   assign cnt_a3     = out_k_q.a3;
   assign cnt_b0     = out_k_q.b0;
   assign cnt_b1     = out_k_q.b1;
   assign cnt_b2     = out_k_q.b2;
   assign cnt_b3     = out_k_q.b3;
   assign cntl_a0    = out_l_q.a0;
   assign cntl_a1    = out_l_q.a1;
   assign cntl_a2    = out_l_q.a2;
   assign cntl_a3    = out_l_q.a3;
   assign cntl_b0    = out_l_q.b0;
   assign cntl_b1    = out_l_q.b1;
   assign cntl_b2    = out_l_q.b2;
   assign cntl_b3    = out_l_q.b3;

endmodule

// File: tb/tb_bwt_occ_responder.sv
// Bench for bwt_occ_responder: table vectors, directed corner sequences and a
// randomized run against an in-order scoreboard with a line-content model.
module tb_bwt_occ_responder;

   localparam int unsigned SLOTS = 8;
   localparam int unsigned RNW   = 6;

   logic           clk = 1'b0;
   logic           rst;
   logic           request_valid, request_ready;
   logic [RNW-1:0] read_num_req;
   logic [41:0]    addr_k, addr_l;
   logic           mem_rd_valid, mem_rd_ready;
   logic [41:0]    mem_rd_addr;
   logic [3:0]     mem_rd_tag;
   logic           mem_resp_valid;
   logic [3:0]     mem_resp_tag;
   logic [511:0]   mem_resp_data;
   logic           stall, resp_valid;
   logic [RNW-1:0] read_num;
   logic [31:0]    cnt_a0, cnt_a1, cnt_a2, cnt_a3, cntl_a0, cntl_a1, cntl_a2, cntl_a3;
   logic [63:0]    cnt_b0, cnt_b1, cnt_b2, cnt_b3, cntl_b0, cntl_b1, cntl_b2, cntl_b3;

   always #5 clk = ~clk;

   bwt_occ_responder #(.SLOTS(SLOTS), .READ_NUM_WIDTH(RNW)) dut (
      .clk(clk), .rst(rst), .request_valid(request_valid), .request_ready(request_ready),
      .read_num_req(read_num_req), .addr_k(addr_k), .addr_l(addr_l),
      .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
      .mem_rd_tag(mem_rd_tag), .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
      .mem_resp_data(mem_resp_data), .stall(stall), .resp_valid(resp_valid),
      .read_num(read_num),
      .cnt_a0(cnt_a0), .cnt_a1(cnt_a1), .cnt_a2(cnt_a2), .cnt_a3(cnt_a3),
      .cnt_b0(cnt_b0), .cnt_b1(cnt_b1), .cnt_b2(cnt_b2), .cnt_b3(cnt_b3),
      .cntl_a0(cntl_a0), .cntl_a1(cntl_a1), .cntl_a2(cntl_a2), .cntl_a3(cntl_a3),
      .cntl_b0(cntl_b0), .cntl_b1(cntl_b1), .cntl_b2(cntl_b2), .cntl_b3(cntl_b3)
   );

   typedef struct { logic [RNW-1:0] rn; logic [41:0] ak; logic [41:0] al; } req_t;
   typedef struct { logic [41:0] addr; logic [3:0] tag; } rd_t;
   typedef struct { logic [RNW-1:0] rn; logic [41:0] ak; logic [41:0] al; int nrd; } vec_t;

   req_t sb[$];
   rd_t  rdq[$];
   int   checks = 0, errors = 0, n_acc = 0, n_out = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory content model: every 32-bit word depends on the address and its position.
   function automatic logic [511:0] mk_line(input logic [41:0] a);
      logic [511:0] l;
      for (int i = 0; i < 16; i++)
         l[32*i +: 32] = (a[31:0] * 32'h9E3779B1) ^ {22'h0, a[41:32]} ^
                         (32'(i) * 32'h01000193) ^ 32'h5A5A0000;
      return l;
   endfunction

   // Counter image of a line: the low 384 bits, in struct order b3..a0.
   function automatic logic [383:0] exp_cnt(input logic [41:0] a);
      logic [511:0] l;
      l = mk_line(a);
      return l[383:0];
   endfunction

   req_t         e;
   logic [383:0] got_k, got_l;

   always @(negedge clk) begin
      if (!rst) begin
         if (request_valid && request_ready) begin
            sb.push_back('{read_num_req, addr_k, addr_l});
            n_acc++;
         end
         if (mem_rd_valid && mem_rd_ready) rdq.push_back('{mem_rd_addr, mem_rd_tag});
         if (resp_valid && !stall) begin
            n_out++;
            check("resp_expected", 512'(sb.size() != 0), 512'd1);
            if (sb.size() != 0) begin
               e     = sb.pop_front();
               got_k = {cnt_b3, cnt_b2, cnt_b1, cnt_b0, cnt_a3, cnt_a2, cnt_a1, cnt_a0};
               got_l = {cntl_b3, cntl_b2, cntl_b1, cntl_b0, cntl_a3, cntl_a2, cntl_a1, cntl_a0};
               check("resp_read_num", 512'(read_num), 512'(e.rn));
               check("resp_cnt_k", 512'(got_k), 512'(exp_cnt(e.ak)));
               check("resp_cnt_l", 512'(got_l), 512'(exp_cnt(e.al)));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [RNW-1:0] rn, input logic [41:0] ak, input logic [41:0] al);
      logic acc;
      acc           = 1'b0;
      request_valid = 1'b1;
      read_num_req  = rn;
      addr_k        = ak;
      addr_l        = al;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = request_ready;
         step();
      end
      request_valid = 1'b0;
      check("req_accept", 512'(acc), 512'd1);
   endtask

   task automatic respond(input rd_t r);
      mem_resp_valid = 1'b1;
      mem_resp_tag   = r.tag;
      mem_resp_data  = mk_line(r.addr);
      step();
      mem_resp_valid = 1'b0;
   endtask

   task automatic wait_reads(input int n, input string name);
      for (int i = 0; i < 60 && rdq.size() < n; i++) step();
      repeat (3) step();
      check(name, 512'(rdq.size()), 512'(n));
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 300 && (sb.size() != 0 || resp_valid); i++) step();
      check(name, 512'(sb.size()), 512'd0);
   endtask

   vec_t         vt[4];
   int           slot, n0;
   rd_t          r0, r1;
   logic [389:0] held;
   logic         acc;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; request_valid = 1'b0; read_num_req = '0; addr_k = '0; addr_l = '0;
      mem_rd_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
      stall = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("rst_request_ready", 512'(request_ready), 512'd1);
      check("rst_ctrl_zero", 512'({resp_valid, mem_rd_valid, read_num, mem_rd_tag, mem_rd_addr}),
            512'd0);
      check("rst_cnt_zero", 512'({cnt_b3, cnt_b2, cnt_b1, cnt_b0, cnt_a3, cnt_a2, cnt_a1, cnt_a0,
            cntl_b3, cntl_b2, cntl_b1, cntl_b0, cntl_a3, cntl_a2, cntl_a1, cntl_a0}), 512'd0);
      step();
      rst = 1'b0;
      step();

      // Single-request vectors: nrd is the number of memory reads the request must cause.
      vt[0] = '{6'd5,  42'h100,          42'h200,          2};
      vt[1] = '{6'd7,  42'h3FF,          42'h3FF,          1};
      vt[2] = '{6'd9,  42'h3FF_FFFF_FFFF, 42'h0,           2};
      vt[3] = '{6'd12, 42'h12_3456_789A, 42'h12_3456_789A, 1};
      mem_rd_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         slot = n_acc % SLOTS;
         send(vt[v].rn, vt[v].ak, vt[v].al);
         @(negedge clk);
         check("issue_latency", 512'(mem_rd_valid), 512'd1);
         step();
         wait_reads(vt[v].nrd, "read_count");
         if (rdq.size() > 0) begin
            check("k_tag", 512'(rdq[0].tag), 512'({3'(slot), 1'b0}));
            check("k_addr", 512'(rdq[0].addr), 512'(vt[v].ak));
         end
         if (vt[v].nrd == 2 && rdq.size() > 1) begin
            check("l_tag", 512'(rdq[1].tag), 512'({3'(slot), 1'b1}));
            check("l_addr", 512'(rdq[1].addr), 512'(vt[v].al));
         end
         while (rdq.size() > 0) respond(rdq.pop_front());
         @(negedge clk);
         check("return_latency", 512'(resp_valid), 512'd1);
         step();
         wait_empty("vec_drain");
      end

      // Out-of-order return: lines come back newest first.
      for (int i = 1; i <= 3; i++) send(6'(i), 42'h1000 * i, 42'h1000 * i + 42'h40);
      wait_reads(6, "ooo_reads");
      n0 = n_out;
      while (rdq.size() > 0) respond(rdq.pop_back());
      wait_empty("ooo_drain");
      check("ooo_count", 512'(n_out - n0), 512'd3);

      // Fill every slot, then free the oldest one.
      for (int i = 0; i < 8; i++) send(6'(16 + i), 42'h2000 + 42'(2 * i), 42'h2001 + 42'(2 * i));
      @(negedge clk);
      check("full_ready_low", 512'(request_ready), 512'd0);
      step();
      wait_reads(16, "full_reads");
      r0 = rdq.pop_front();
      r1 = rdq.pop_front();
      respond(r0);
      mem_resp_valid = 1'b1;
      mem_resp_tag   = r1.tag;
      mem_resp_data  = mk_line(r1.addr);
      @(negedge clk);
      check("full_low_during_retire", 512'(request_ready), 512'd0);
      step();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      check("full_ready_after_retire", 512'(request_ready), 512'd1);
      step();
      while (rdq.size() > 0) respond(rdq.pop_front());
      wait_empty("full_drain");

      // Downstream stall holds the output register.
      stall = 1'b1;
      send(6'd33, 42'h3000, 42'h3100);
      wait_reads(2, "stall_reads");
      while (rdq.size() > 0) respond(rdq.pop_front());
      for (int i = 0; i < 20 && !resp_valid; i++) step();
      check("stall_valid", 512'(resp_valid), 512'd1);
      held = {read_num, cnt_b3, cnt_b2, cnt_b1, cnt_b0, cnt_a3, cnt_a2, cnt_a1, cnt_a0};
      repeat (5) begin
         @(negedge clk);
         check("stall_hold_valid", 512'(resp_valid), 512'd1);
         check("stall_hold_data", 512'({read_num, cnt_b3, cnt_b2, cnt_b1, cnt_b0, cnt_a3,
               cnt_a2, cnt_a1, cnt_a0}), 512'(held));
         step();
      end
      n0    = n_out;
      stall = 1'b0;
      step();
      @(negedge clk);
      check("stall_consumed", 512'(n_out - n0), 512'd1);
      check("stall_cleared", 512'(resp_valid), 512'd0);
      step();

      // Reset with four requests in flight; their late lines must be ignored.
      for (int i = 0; i < 4; i++) send(6'(40 + i), 42'h4000 + 42'(2 * i), 42'h4001 + 42'(2 * i));
      wait_reads(8, "rst_reads");
      rst = 1'b1;
      sb.delete();
      repeat (2) step();
      rst   = 1'b0;
      n_acc = 0;
      n0    = n_out;
      while (rdq.size() > 0) respond(rdq.pop_front());
      repeat (5) step();
      @(negedge clk);
      check("rst_no_resp", 512'(n_out - n0), 512'd0);
      check("rst_resp_valid", 512'(resp_valid), 512'd0);
      check("rst_ready", 512'(request_ready), 512'd1);
      check("rst_rd_idle", 512'(mem_rd_valid), 512'd0);
      step();

      // Randomized traffic with out-of-order returns, backpressure and stalls.
      n0 = n_out;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = request_valid & request_ready;
         step();
         if (!request_valid || acc) begin
            request_valid = ($urandom_range(0, 2) == 0);
            read_num_req  = 6'($urandom);
            addr_k        = 42'({$urandom_range(0, 1023), $urandom});
            addr_l        = ($urandom_range(0, 3) == 0) ? addr_k :
                            42'({$urandom_range(0, 1023), $urandom});
         end
         mem_rd_ready = ($urandom_range(0, 3) != 0);
         stall        = ($urandom_range(0, 3) == 0);
         if (rdq.size() > 0 && $urandom_range(0, 1) == 1) begin
            slot           = $urandom_range(0, rdq.size() - 1);
            r0             = rdq[slot];
            rdq.delete(slot);
            mem_resp_valid = 1'b1;
            mem_resp_tag   = r0.tag;
            mem_resp_data  = mk_line(r0.addr);
         end else begin
            mem_resp_valid = 1'b0;
         end
      end
      request_valid = 1'b0;
      stall         = 1'b0;
      mem_rd_ready  = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 1000 && (sb.size() != 0 || rdq.size() != 0 || resp_valid); i++) begin
         if (rdq.size() > 0) respond(rdq.pop_front());
         else step();
      end
      check("random_drain", 512'(sb.size()), 512'd0);
      check("random_outputs", 512'(n_out > n0 + 50), 512'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bwt_occ_responder.md
# bwt_occ_responder

Memory-side responder for the backward-extension occurrence lookups. It accepts a `{read_num, addr_k, addr_l}` request from the backward data path and issues the 512-bit cache-line reads to host memory. It collects the lines, which may return out of order, slices out the occurrence counters, and returns them in request order as the `cnt_*` / `cntl_*` operand set consumed by the BWT extend stage. It sits between the backward data path's request port and the memory read channel.

## Interface
- `SLOTS`, 8: outstanding request slots; power of two, 2..16.
- `READ_NUM_WIDTH`, 6: read-number width; equals the shared `READ_NUM_WIDTH`.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `request_valid`  in  1  new lookup request
- `request_ready`  out  1  a slot is free; request accepted when valid & ready
- `read_num_req`  in  READ_NUM_WIDTH  read number tagged to the request
- `addr_k`, `addr_l`  in  42 each  cache-line addresses for k and l
- `mem_rd_valid`  out  1  memory read issue
- `mem_rd_ready`  in  1  memory accepts the read
- `mem_rd_addr`  out  42  line address
- `mem_rd_tag`  out  $clog2(SLOTS)+1  {slot, half}; half 0 = k, 1 = l
- `mem_resp_valid`  in  1  line returned; always accepted, no backpressure
- `mem_resp_tag`  in  $clog2(SLOTS)+1  tag echoed from the issue
- `mem_resp_data`  in  512  cache line
- `stall`  in  1  downstream hold
- `resp_valid`  out  1  operand set valid
- `read_num`  out  READ_NUM_WIDTH  read number of the returned set
- `cnt_a0..3`  out  32 each  k-line counters
- `cnt_b0..3`  out  64 each  k-line counters
- `cntl_a0..3`  out  32 each  l-line counters
- `cntl_b0..3`  out  64 each  l-line counters

## Operation
- Line layout:
  - `a_i` = data[32i+31:32i], i = 0..3.
  - `b_i` = data[128+64i+63:128+64i].
  - Bits 511:384 are discarded.
- Slots form a circular buffer with alloc pointer, issue pointer and retire pointer, plus a count.
- `request_ready` = (count < SLOTS).
- On accept, the slot at alloc stores read_num, addr_k and addr_l, sets `same` = (addr_k == addr_l), clears `got_k` and `got_l`, and alloc advances.
- Issue FSM states:
  - `IDLE`: waits until issue != alloc, then goes to `ISSUE_K`.
  - `ISSUE_K`: drives addr_k with tag {issue, 0}. On handshake, if `same`, advances issue and returns to `IDLE`; otherwise goes to `ISSUE_L`.
  - `ISSUE_L`: drives addr_l with tag {issue, 1}. On handshake, advances issue and goes to `IDLE`.
- `mem_rd_valid`/`mem_rd_addr`/`mem_rd_tag` hold stable until `mem_rd_ready`.
- Response fill:
  - Half 0 writes the k fields and sets `got_k`.
  - If `same`, half 0 also writes the l fields and sets `got_l`.
  - Half 1 writes the l fields and sets `got_l`.
  - A response to a slot that is not in flight is ignored. This is a protocol error and a bench assertion.
- Retire: when the retire slot has `got_k & got_l` and the output register is empty or being consumed, the slot loads the output register, frees, and retire advances.
- The output register holds while `stall`=1. It is consumed when `resp_valid & !stall`.
- An accept and a retire in the same cycle leave count unchanged.

## Timing
- Reset values:
  - all outputs 0, except `request_ready`=1;
  - FSM in `IDLE`;
  - all pointers and count 0;
  - all `got_*` bits 0.
- Reset asserted mid-operation drops every in-flight slot. Late memory responses after reset are ignored: no slot is in flight.
- Issue latency: request accepted at cycle t gives `mem_rd_valid` at t+1 at the earliest; the l read goes out at the earliest one cycle after the k handshake.
- Return latency: last line arriving at cycle t, slot at head, register free gives `resp_valid` at t+1.
- Throughput: one read per cycle when `mem_rd_ready` is held high, i.e. one request per 2 cycles (1 when `same`).
- Full: with count == SLOTS, `request_ready`=0 in the same cycle. A retire in cycle t raises `request_ready` in cycle t+1 (registered).

## Structure
- Shared package `smem_pkg`: `READ_NUM_WIDTH`, `CL`=512, line-field offsets, and a struct `occ_cnt_t` {a0..a3, b0..b3}.
- Sub-module `occ_line_slice`: combinational 512-bit → `occ_cnt_t`; instantiate it once on `mem_resp_data`.
- Slot storage: 2×`occ_cnt_t` per slot plus metadata, as flops.

## Test plan
- Single request: read_num=5, addr_k=0x100, addr_l=0x200; lines returned in order → two reads with tags {0,0} and {0,1}; `resp_valid` one cycle after the second line; `cnt_a0`=k line[31:0], `cntl_b3`=l line[383:320].
- Equal addresses: addr_k=addr_l=0x3FF → exactly one memory read; `cnt_*` == `cntl_*`.
- Out-of-order return: 3 requests (read_num 1, 2, 3) with lines returned in reverse order → responses still emitted as 1, 2, 3.
- Full condition: 8 requests, no memory responses → `request_ready`=0 after the 8th accept. Release one slot's lines → `request_ready`=1 one cycle after its retire.
- Stall: `stall`=1 for 5 cycles while a response is ready → `resp_valid` and the data stay constant; the set is consumed in the first cycle with `stall`=0.
- Reset mid-flight: assert `rst` with 4 slots pending, then return their lines → no `resp_valid`; `request_ready`=1.
